// File: rtl/mem_stage_pkg.sv
// Shared widths, field layouts and state encodings for the memory-access stage.
package mem_stage_pkg;

    localparam int M_RFC_WID = 38;
    localparam int EXC_WID   = 7;
    localparam int LDOP_WID  = 5;

    // Bit positions inside the one-hot load-op vector {ld_b, ld_h, ld_w, ld_bu, ld_hu}
    localparam int LD_B  = 4;
    localparam int LD_H  = 3;
    localparam int LD_W  = 2;
    localparam int LD_BU = 1;
    localparam int LD_HU = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_collect_t;

    // Exception vector layout, msb first
    typedef struct packed {
        logic ale;
        logic adef;
        logic ine;
        logic sys;
        logic brk;
        logic intr;
        logic ertn;
    } except_t;

    typedef struct packed {
        logic [31:0]         pc;
        rf_collect_t         rfc;
        logic [LDOP_WID-1:0] ld_op;
        logic                need_data;
        except_t             except;
        logic [31:0]         vaddr;
    } ms_payload_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half of the SRAM response and extends it to 32 bits.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0]         rdata_i,
    input  logic [1:0]          offset_i,
    input  logic [LDOP_WID-1:0] ld_op_i,
    input  logic [31:0]         alu_i,
    output logic [31:0]         wdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
    end

    assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        wdata_o = alu_i;
        if (ld_op_i[LD_W])       wdata_o = rdata_i;
        else if (ld_op_i[LD_B])  wdata_o = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_op_i[LD_BU]) wdata_o = {24'd0, byte_sel};
        else if (ld_op_i[LD_H])  wdata_o = {{16{half_sel[15]}}, half_sel};
        else if (ld_op_i[LD_HU]) wdata_o = {16'd0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// MS pipeline stage: holds the ES payload, waits for the data-SRAM response and
// drops responses that belong to flushed instructions.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_OUTST = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allowin,
    input  logic [31:0]          es_pc,
    input  logic [M_RFC_WID-1:0] es_rf_collect,
    input  logic [LDOP_WID-1:0]  es_ld_op,
    input  logic                 es_mem_req,
    input  logic [EXC_WID-1:0]   es_except,
    input  logic [31:0]          es_vaddr,
    input  logic                 data_req_hs,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    output logic                 ms_to_ws_valid,
    input  logic                 ws_allowin,
    output logic [31:0]          ms_pc,
    output logic [M_RFC_WID-1:0] ms_rf_collect,
    output logic [EXC_WID-1:0]   ms_to_ws_except,
    output logic [31:0]          ms_vaddr,
    input  logic                 wb_flush,
    output logic                 ms_ex,
    output logic [M_RFC_WID:0]   ms_rf_fwd
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    logic           ms_valid_q, ms_valid_d;
    ms_payload_t    pl_q, pl_d;
    logic           got_q, got_d;
    logic [31:0]    buf_q, buf_d;
    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  discard_q, discard_d;

    logic           ms_ready_go, consume, handoff, accept, load_pending;
    logic [31:0]    ld_rdata, final_wdata;
    int             inflight;

    // A response is ours only once every response owed to flushed work has drained
    assign consume      = ms_valid_q & pl_q.need_data & ~got_q & data_sram_data_ok & (discard_q == '0);
    assign ms_ready_go  = ~pl_q.need_data | got_q | (data_sram_data_ok & (discard_q == '0));
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
    assign handoff      = ms_to_ws_valid & ws_allowin;
    assign ms_allowin   = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign accept       = es_to_ms_valid & ms_allowin;

    always_comb begin
        ms_valid_d = ms_valid_q;
        pl_d       = pl_q;
        got_d      = got_q;
        buf_d      = buf_q;
        if (ms_allowin) ms_valid_d = es_to_ms_valid;
        if (wb_flush)   ms_valid_d = 1'b0;
        if (accept) begin
            pl_d.pc        = es_pc;
            pl_d.rfc       = rf_collect_t'(es_rf_collect);
            pl_d.ld_op     = es_ld_op;
            pl_d.need_data = es_mem_req & (es_except == '0);
            pl_d.except    = except_t'(es_except);
            pl_d.vaddr     = es_vaddr;
            got_d          = 1'b0;
        end else if (wb_flush | handoff) begin
            got_d = 1'b0;
        end else if (consume) begin
            got_d = 1'b1;
        end
        if (consume) buf_d = data_sram_rdata;

        if (!ms_valid_d)         state_d = ST_IDLE;
        else if (got_d)          state_d = ST_HOLD;
        else if (pl_d.need_data) state_d = ST_WAIT;
        else                     state_d = ST_IDLE;
    end

    always_comb begin
        outst_d   = outst_q + CW'(data_req_hs) - CW'(data_sram_data_ok);
        discard_d = discard_q;
        inflight  = int'(outst_q) + int'(data_req_hs) - int'(data_sram_data_ok)
                  - int'(consume & handoff);
        if (wb_flush)
            discard_d = (inflight > 0) ? CW'(inflight) : '0;
        else if ((discard_q != '0) && data_sram_data_ok)
            discard_d = discard_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            pl_q       <= '0;
            got_q      <= 1'b0;
            buf_q      <= '0;
            state_q    <= ST_IDLE;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            ms_valid_q <= ms_valid_d;
            pl_q       <= pl_d;
            got_q      <= got_d;
            buf_q      <= buf_d;
            state_q    <= state_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    always @(posedge clk) begin
        if (!reset && outst_q == CW'(MAX_OUTST))
            assert (!data_req_hs || data_sram_data_ok);
    end

    assign ld_rdata = got_q ? buf_q : data_sram_rdata;

    mem_stage_load_align u_align (
        .rdata_i  (ld_rdata),
        .offset_i (pl_q.vaddr[1:0]),
        .ld_op_i  (pl_q.ld_op),
        .alu_i    (pl_q.rfc.wdata),
        .wdata_o  (final_wdata)
    );

    assign load_pending    = ms_valid_q & (pl_q.ld_op != '0) & ~ms_ready_go;
    assign ms_pc           = pl_q.pc;
    assign ms_vaddr        = pl_q.vaddr;
    assign ms_to_ws_except = pl_q.except;
    assign ms_ex           = ms_valid_q & (pl_q.except != '0);
    assign ms_rf_collect   = {pl_q.rfc.we & ms_valid_q & (pl_q.except == '0),
                              pl_q.rfc.waddr, final_wdata};
    assign ms_rf_fwd       = {pl_q.rfc.we & ms_valid_q, pl_q.rfc.waddr, final_wdata, load_pending};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of load-align vectors plus multi-cycle sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        es_to_ms_valid, ms_allowin;
    logic [31:0] es_pc;
    logic [37:0] es_rf_collect;
    logic [4:0]  es_ld_op;
    logic        es_mem_req;
    logic [6:0]  es_except;
    logic [31:0] es_vaddr;
    logic        data_req_hs, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid, ws_allowin;
    logic [31:0] ms_pc;
    logic [37:0] ms_rf_collect;
    logic [6:0]  ms_to_ws_except;
    logic [31:0] ms_vaddr;
    logic        wb_flush, ms_ex;
    logic [38:0] ms_rf_fwd;

    mem_stage #(.MAX_OUTST(2)) dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_rf_collect(es_rf_collect), .es_ld_op(es_ld_op),
        .es_mem_req(es_mem_req), .es_except(es_except), .es_vaddr(es_vaddr),
        .data_req_hs(data_req_hs), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_rf_collect(ms_rf_collect), .ms_to_ws_except(ms_to_ws_except),
        .ms_vaddr(ms_vaddr), .wb_flush(wb_flush), .ms_ex(ms_ex), .ms_rf_fwd(ms_rf_fwd)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] OP_B  = 5'b10000;
    localparam logic [4:0] OP_H  = 5'b01000;
    localparam logic [4:0] OP_W  = 5'b00100;
    localparam logic [4:0] OP_BU = 5'b00010;
    localparam logic [4:0] OP_HU = 5'b00001;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] va;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        es_mem_req        = 1'b0;
        es_ld_op          = '0;
        es_except         = '0;
        data_req_hs       = 1'b0;
        data_sram_data_ok = 1'b0;
        wb_flush          = 1'b0;
        ws_allowin        = 1'b1;
    endtask

    // Presents an ES instruction; a memory instruction also has its request accepted now
    task automatic issue(input logic [4:0] op, input logic [31:0] va, input logic [4:0] wa,
                         input logic [31:0] alu, input logic mreq, input logic [6:0] exc);
        es_to_ms_valid = 1'b1;
        es_pc          = 32'h1c00_0000 | va;
        es_rf_collect  = {1'b1, wa, alu};
        es_ld_op       = op;
        es_mem_req     = mreq;
        es_except      = exc;
        es_vaddr       = va;
        data_req_hs    = mreq;
    endtask

    initial begin
        vecs[0] = '{OP_B,  32'h0000_1003, 32'h8012_3456, 32'hFFFF_FF80};
        vecs[1] = '{OP_HU, 32'h0000_1002, 32'h8012_3456, 32'h0000_8012};
        vecs[2] = '{OP_H,  32'h0000_1002, 32'h8012_3456, 32'hFFFF_8012};
        vecs[3] = '{OP_BU, 32'h0000_1003, 32'h8012_3456, 32'h0000_0080};
        vecs[4] = '{OP_B,  32'h0000_1000, 32'h8012_3456, 32'h0000_0056};
        vecs[5] = '{OP_B,  32'h0000_1001, 32'h8012_3456, 32'h0000_0034};
        vecs[6] = '{OP_H,  32'h0000_1000, 32'h1234_F00D, 32'hFFFF_F00D};
        vecs[7] = '{OP_W,  32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[8] = '{OP_BU, 32'h0000_1002, 32'h00AB_0000, 32'h0000_00AB};
        vecs[9] = '{OP_HU, 32'h0000_1000, 32'hFFFF_7FFF, 32'h0000_7FFF};

        es_pc = '0; es_rf_collect = '0; es_vaddr = '0; data_sram_rdata = '0;
        idle();
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid",   64'(ms_to_ws_valid), 64'(0));
        chk("rst_rfc",     64'(ms_rf_collect), 64'(0));
        chk("rst_fwd",     64'(ms_rf_fwd), 64'(0));
        chk("rst_ex",      64'(ms_ex), 64'(0));
        chk("rst_allowin", 64'(ms_allowin), 64'(1));
        chk("rst_state",   64'(dut.state_q), 64'(ST_IDLE));

        // ld_w: response in the second MS cycle
        @(negedge clk); issue(OP_W, 32'h1000, 5'd4, 32'h55, 1'b1, 7'd0);
        #1 chk("ldw_allowin", 64'(ms_allowin), 64'(1));
        @(negedge clk); idle();
        #1 chk("ldw_wait_valid", 64'(ms_to_ws_valid), 64'(0));
        chk("ldw_wait_state", 64'(dut.state_q), 64'(ST_WAIT));
        chk("ldw_pending",    64'(ms_rf_fwd[0]), 64'(1));
        chk("ldw_outst",      64'(dut.outst_q), 64'(1));
        @(negedge clk); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF;
        #1 chk("ldw_valid", 64'(ms_to_ws_valid), 64'(1));
        chk("ldw_rfc", 64'(ms_rf_collect), 64'({1'b1, 5'd4, 32'hDEADBEEF}));
        @(negedge clk); idle();
        #1 chk("ldw_gone", 64'(ms_to_ws_valid), 64'(0));
        chk("ldw_outst0", 64'(dut.outst_q), 64'(0));

        // Alignment table: response in MS's first cycle passes straight through
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); idle(); issue(vecs[i].op, vecs[i].va, 5'd5, 32'h1111_1111, 1'b1, 7'd0);
            @(negedge clk); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = vecs[i].rdata;
            #1 chk($sformatf("vec%0d_valid", i), 64'(ms_to_ws_valid), 64'(1));
            chk($sformatf("vec%0d_rfc", i), 64'(ms_rf_collect), 64'({1'b1, 5'd5, vecs[i].exp}));
        end
        @(negedge clk); idle();

        // HOLD: data arrives while WS stalls for three cycles
        @(negedge clk); issue(OP_W, 32'h2000, 5'd6, 32'h0, 1'b1, 7'd0);
        @(negedge clk); idle(); ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D;
        #1 chk("hold_valid0", 64'(ms_to_ws_valid), 64'(1));
        chk("hold_allowin0", 64'(ms_allowin), 64'(0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle(); ws_allowin = 1'b0; data_sram_rdata = 32'h0BADBAD0;
            #1 chk($sformatf("hold%0d_state", k), 64'(dut.state_q), 64'(ST_HOLD));
            chk($sformatf("hold%0d_rfc", k), 64'(ms_rf_collect), 64'({1'b1, 5'd6, 32'hCAFEF00D}));
        end
        @(negedge clk); idle();
        #1 chk("hold_hand_rfc", 64'(ms_rf_collect), 64'({1'b1, 5'd6, 32'hCAFEF00D}));
        chk("hold_hand_valid",   64'(ms_to_ws_valid), 64'(1));
        chk("hold_hand_allowin", 64'(ms_allowin), 64'(1));
        @(negedge clk); idle();
        #1 chk("hold_after_valid", 64'(ms_to_ws_valid), 64'(0));
        chk("hold_after_state", 64'(dut.state_q), 64'(ST_IDLE));
        chk("hold_after_outst", 64'(dut.outst_q), 64'(0));

        // Flush with two requests in flight; the next load takes only the third response
        @(negedge clk); issue(OP_W, 32'h3000, 5'd7, 32'h0, 1'b1, 7'd0);
        @(negedge clk); idle(); data_req_hs = 1'b1;
        #1 chk("fl_wait", 64'(dut.state_q), 64'(ST_WAIT));
        @(negedge clk); idle(); wb_flush = 1'b1;
        #1 chk("fl_outst2", 64'(dut.outst_q), 64'(2));
        @(negedge clk); idle(); issue(OP_W, 32'h4000, 5'd8, 32'h0, 1'b1, 7'd0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        #1 chk("fl_discard2", 64'(dut.discard_q), 64'(2));
        chk("fl_valid_c4",   64'(ms_to_ws_valid), 64'(0));
        chk("fl_allowin_c4", 64'(ms_allowin), 64'(1));
        @(negedge clk); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
        #1 chk("fl_discard1", 64'(dut.discard_q), 64'(1));
        chk("fl_valid_c5", 64'(ms_to_ws_valid), 64'(0));
        chk("fl_pending",  64'(ms_rf_fwd[0]), 64'(1));
        chk("fl_outst_c5", 64'(dut.outst_q), 64'(2));
        @(negedge clk); idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333;
        #1 chk("fl_discard0", 64'(dut.discard_q), 64'(0));
        chk("fl_valid_c6", 64'(ms_to_ws_valid), 64'(1));
        chk("fl_rfc",      64'(ms_rf_collect), 64'({1'b1, 5'd8, 32'h3333_3333}));
        @(negedge clk); idle();
        #1 chk("fl_outst0", 64'(dut.outst_q), 64'(0));
        chk("fl_done", 64'(ms_to_ws_valid), 64'(0));

        // Exception instruction, then a plain ALU instruction behind it
        @(negedge clk); issue(OP_W, 32'hBAD1, 5'd9, 32'hAAAA, 1'b0, 7'b100_0000);
        @(negedge clk); idle(); issue(5'd0, 32'h0, 5'd7, 32'h1234_5678, 1'b0, 7'd0);
        #1 chk("exc_valid", 64'(ms_to_ws_valid), 64'(1));
        chk("exc_ex",      64'(ms_ex), 64'(1));
        chk("exc_we",      64'(ms_rf_collect[37]), 64'(0));
        chk("exc_vec",     64'(ms_to_ws_except), 64'(7'b100_0000));
        chk("exc_vaddr",   64'(ms_vaddr), 64'(32'hBAD1));
        chk("exc_pending", 64'(ms_rf_fwd[0]), 64'(0));
        @(negedge clk); idle();
        #1 chk("alu_ex", 64'(ms_ex), 64'(0));
        chk("alu_valid", 64'(ms_to_ws_valid), 64'(1));
        chk("alu_fwd",   64'(ms_rf_fwd), 64'({1'b1, 5'd7, 32'h1234_5678, 1'b0}));
        @(negedge clk); idle();
        #1 chk("alu_gone", 64'(ms_to_ws_valid), 64'(0));

        // Asynchronous reset in the middle of a WAIT with a pending discard
        @(negedge clk); issue(OP_W, 32'h5000, 5'd10, 32'h0, 1'b1, 7'd0);
        @(negedge clk); idle(); wb_flush = 1'b1;
        @(negedge clk); idle(); issue(OP_W, 32'h6000, 5'd11, 32'h0, 1'b1, 7'd0);
        #1 chk("rw_discard1", 64'(dut.discard_q), 64'(1));
        @(negedge clk); idle();
        #1 chk("rw_state", 64'(dut.state_q), 64'(ST_WAIT));
        chk("rw_outst2", 64'(dut.outst_q), 64'(2));
        #2 reset = 1'b1;
        #1 chk("rw_valid", 64'(ms_to_ws_valid), 64'(0));
        chk("rw_rfc",     64'(ms_rf_collect), 64'(0));
        chk("rw_fwd",     64'(ms_rf_fwd), 64'(0));
        chk("rw_ex",      64'(ms_ex), 64'(0));
        chk("rw_pc",      64'(ms_pc), 64'(0));
        chk("rw_outst",   64'(dut.outst_q), 64'(0));
        chk("rw_discard", 64'(dut.discard_q), 64'(0));
        chk("rw_state0",  64'(dut.state_q), 64'(ST_IDLE));
        @(negedge clk); reset = 1'b0; idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
